load_align_wb: RTL and testbench
================================

LOAD_ALIGN_WB -- requirements
Module: load_align_wb

Interface
REQ-001 Parameters: none; data width fixed at 32, register index 5 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  hold M/W register and outputs this cycle.
REQ-005 flush  in  1  insert bubble into W on next edge.
REQ-006 M_op  in  7  MEM-stage opcode.
REQ-007 M_funct3  in  3  MEM-stage funct3.
REQ-008 M_alu_out  in  32  MEM-stage effective address / ALU result.
REQ-009 M_rd  in  5  MEM-stage destination register.
REQ-010 M_reg_write  in  1  MEM-stage register write enable.
REQ-011 dm_data_out  in  32  SRAM read word; valid the first cycle after the address was presented, i.e. the first W cycle of a load.
REQ-012 W_rd  out  5  WB destination register.
REQ-013 W_reg_write  out  1  WB write enable; forced 0 for bubbles and rd==0.
REQ-014 W_wb_data  out  32  WB write-back value (aligned/extended load data or ALU result).
REQ-015 W_is_load  out  1  W holds a load, for forwarding/hazard logic.

Function
REQ-016 The M/W register (op, funct3, alu_out[31:0], rd, reg_write) loads from M_* on each edge with stall=0 and flush=0.
REQ-017 With stall=1, the M/W register and all outputs hold; stall has priority over flush.
REQ-018 With flush=1 and stall=0, the next W contents are a bubble: reg_write=0, is_load=0, rd=0, data=0.
REQ-019 Load detection: op==OP_LOAD (7'b0000011); W_is_load = registered load flag.
REQ-020 Hold buffer: on the first W cycle of a load (fresh flag=1), dm_data_out is used directly and captured into hold_q; fresh clears to 0 on that edge.
REQ-021 Stalled W cycles after the first use hold_q, not dm_data_out; fresh re-arms to 1 when a new instruction enters W.
REQ-022 Alignment uses registered offset = alu_out[1:0].
REQ-023 LB (000)/LBU (100): byte at offset (0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]), sign-/zero-extended to 32.
REQ-024 LH (001)/LHU (101): offset[1]=0→[15:0], 1→[31:16]; offset[0] is ignored; sign-/zero-extended.
REQ-025 LW (010): full word; offset ignored.
REQ-026 Load with any other funct3: W_wb_data=0 and W_reg_write=0.
REQ-027 Non-load: W_wb_data = registered alu_out.
REQ-028 W_reg_write = registered reg_write AND (rd!=0).
REQ-029 Latency: a load issued in M at cycle N produces W_wb_data combinationally in cycle N+1.

Reset
REQ-030 When rst=1 at an edge: M/W register cleared to a bubble, hold_q=0, fresh=1; W_reg_write=0, W_is_load=0, W_rd=0, W_wb_data=0.
REQ-031 rst overrides stall and flush; reset asserted with a load in W discards the load.

Structure
REQ-032 The shared package cpu_pkg holds OP_LOAD and the funct3 constants F3_LB/LH/LW/LBU/LHU.
REQ-033 The combinational sub-module load_extender (inputs: word, offset, funct3; output: 32-bit result) performs REQ-023..026.

Verification
REQ-034 LB at addr 0x103, dm_data_out=0x80FF_1234 -> W_wb_data=0xFFFF_FF80, W_reg_write=1.
REQ-035 LHU at addr 0x102, dm_data_out=0xBEEF_0000 -> 0x0000_BEEF; LH at the same address -> 0xFFFF_BEEF.
REQ-036 LW 0xDEAD_BEEF, then stall=1 for 3 cycles with dm_data_out changed to 0x0 -> W_wb_data stays 0xDEAD_BEEF throughout.
REQ-037 flush=1 with an ALU op (rd=5, result 0x42) in M -> next W_reg_write=0, W_wb_data=0; with stall=1 and flush=1 together -> W unchanged.
REQ-038 Load with rd=0 -> W_reg_write=0; load with funct3=011 -> W_wb_data=0, W_reg_write=0.
REQ-039 rst=1 during a stalled load in W -> next cycle all outputs 0, fresh=1; the following load uses live dm_data_out.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: load opcode and load funct3 encodings, plus a helper
// that tells whether a funct3 value names a supported load width.
package cpu_pkg;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic f3_is_load(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load alignment: picks the byte/half/word addressed by offset
// out of the SRAM word and sign- or zero-extends it to 32 bits.
// Ports:
//   word   - 32-bit memory word
//   offset - low two address bits
//   funct3 - load width/sign selector
//   result - aligned, extended value (0 for unsupported funct3)
module load_extender
  import cpu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    unique case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'd0, half_sel};
      F3_LW:   result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_align_wb.sv
// MEM/WB pipeline register with load alignment and a hold buffer that keeps
// the SRAM read word alive while the WB stage is stalled.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   stall, flush             - hold M/W (priority) / insert bubble
//   M_op, M_funct3, M_alu_out, M_rd, M_reg_write - MEM-stage instruction
//   dm_data_out              - SRAM read word, valid on first W cycle of a load
//   W_rd, W_reg_write, W_wb_data, W_is_load      - WB-stage results
module load_align_wb
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [6:0]  M_op,
  input  logic [2:0]  M_funct3,
  input  logic [31:0] M_alu_out,
  input  logic [4:0]  M_rd,
  input  logic        M_reg_write,
  input  logic [31:0] dm_data_out,
  output logic [4:0]  W_rd,
  output logic        W_reg_write,
  output logic [31:0] W_wb_data,
  output logic        W_is_load
);

  // The opcode is only ever consumed as "is this a load", so it is stored
  // already reduced to that flag.
  logic        is_load_q, is_load_d;
  logic [2:0]  funct3_q,  funct3_d;
  logic [31:0] alu_q,     alu_d;
  logic [4:0]  rd_q,      rd_d;
  logic        rw_q,      rw_d;
  logic [31:0] hold_q,    hold_d;
  logic        fresh_q,   fresh_d;

  logic [31:0] load_word;
  logic [31:0] ext_result;

  always_comb begin
    is_load_d = is_load_q;
    funct3_d  = funct3_q;
    alu_d     = alu_q;
    rd_d      = rd_q;
    rw_d      = rw_q;
    hold_d    = hold_q;
    fresh_d   = fresh_q;
    if (rst) begin
      is_load_d = 1'b0;
      funct3_d  = '0;
      alu_d     = '0;
      rd_d      = '0;
      rw_d      = 1'b0;
      hold_d    = '0;
      fresh_d   = 1'b1;
    end else if (!stall) begin
      if (flush) begin
        is_load_d = 1'b0;
        funct3_d  = '0;
        alu_d     = '0;
        rd_d      = '0;
        rw_d      = 1'b0;
      end else begin
        is_load_d = (M_op == OP_LOAD);
        funct3_d  = M_funct3;
        alu_d     = M_alu_out;
        rd_d      = M_rd;
        rw_d      = M_reg_write;
      end
      fresh_d = 1'b1;
    end else if (is_load_q && fresh_q) begin
      // First W cycle of a stalled load: SRAM output moves on next cycle,
      // so keep our own copy.
      hold_d  = dm_data_out;
      fresh_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    is_load_q <= is_load_d;
    funct3_q  <= funct3_d;
    alu_q     <= alu_d;
    rd_q      <= rd_d;
    rw_q      <= rw_d;
    hold_q    <= hold_d;
    fresh_q   <= fresh_d;
  end

  assign load_word = fresh_q ? dm_data_out : hold_q;

  load_extender u_ext (
    .word   (load_word),
    .offset (alu_q[1:0]),
    .funct3 (funct3_q),
    .result (ext_result)
  );

  assign W_rd        = rd_q;
  assign W_is_load   = is_load_q;
  assign W_wb_data   = is_load_q ? ext_result : alu_q;
  assign W_reg_write = rw_q && (rd_q != 5'd0) && (!is_load_q || f3_is_load(funct3_q));

endmodule

// File: tb/tb_load_align_wb.sv
module tb_load_align_wb;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [6:0]  M_op;
  logic [2:0]  M_funct3;
  logic [31:0] M_alu_out;
  logic [4:0]  M_rd;
  logic        M_reg_write;
  logic [31:0] dm_data_out;
  logic [4:0]  W_rd;
  logic        W_reg_write;
  logic [31:0] W_wb_data;
  logic        W_is_load;

  always #5 clk = ~clk;

  load_align_wb dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .M_op(M_op), .M_funct3(M_funct3), .M_alu_out(M_alu_out), .M_rd(M_rd),
    .M_reg_write(M_reg_write), .dm_data_out(dm_data_out),
    .W_rd(W_rd), .W_reg_write(W_reg_write), .W_wb_data(W_wb_data),
    .W_is_load(W_is_load)
  );

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  bit check_en = 1'b0;

  // Model of the instruction sitting in W.
  typedef struct {
    bit          load;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [4:0]  rd;
    bit          we;
  } winst_t;

  winst_t      w;
  bit          w_first;   // current cycle is the instruction's first W cycle
  logic [31:0] w_saved;   // word seen on the first W cycle of a stalled load

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = (32'h1 << bits) - 1;
    v = v & m;
    if (v[bits-1]) return v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] word,
                                             input logic [1:0] off,
                                             input logic [2:0] f3);
    case (f3)
      3'd0: return sx(word >> (8 * off), 8);
      3'd4: return (word >> (8 * off)) & 32'hFF;
      3'd1: return sx(word >> (16 * off[1]), 16);
      3'd5: return (word >> (16 * off[1])) & 32'hFFFF;
      3'd2: return word;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_data();
    logic [31:0] word;
    if (!w.load) return w.addr;
    word = w_first ? dm_data_out : w_saved;
    return load_value(word, w.addr[1:0], w.f3);
  endfunction

  function automatic bit exp_we();
    bit ok_f3;
    ok_f3 = (w.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return w.we && (w.rd != 0) && (!w.load || ok_f3);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, DUT vs. model.
  always @(negedge clk) begin
    if (check_en) begin
      check32("W_rd",        {27'd0, W_rd},        {27'd0, w.rd});
      check32("W_reg_write", {31'd0, W_reg_write}, {31'd0, exp_we()});
      check32("W_is_load",   {31'd0, W_is_load},   {31'd0, w.load});
      check32("W_wb_data",   W_wb_data,            exp_data());
    end
  end

  // Advance one edge and update the model from the inputs present at it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      w = '{0, 3'd0, 32'd0, 5'd0, 0};
      w_first = 1; w_saved = '0;
    end else if (!stall) begin
      if (flush) w = '{0, 3'd0, 32'd0, 5'd0, 0};
      else       w = '{M_op == 7'b0000011, M_funct3, M_alu_out, M_rd, M_reg_write};
      w_first = 1;
    end else if (w_first && w.load) begin
      w_saved = dm_data_out;
      w_first = 0;
    end
    #1;
  endtask

  task automatic set_m(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [4:0] rd, input logic we);
    M_op = op; M_funct3 = f3; M_alu_out = a; M_rd = rd; M_reg_write = we;
  endtask

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ALU = 7'b0110011;

  initial begin
    rst = 1; stall = 0; flush = 0; dm_data_out = '0;
    set_m(ALU, 3'd0, 32'h1234, 5'd7, 1);
    tick();
    check_en = 1;
    rst = 0;
    @(negedge clk);
    check32("reset_data", W_wb_data, 32'h0);
    check32("reset_we", {31'd0, W_reg_write}, 32'd0);

    // LB at 0x103
    set_m(LD, 3'd0, 32'h103, 5'd3, 1); tick();
    set_m(ALU, 3'd0, 32'h0, 5'd0, 0); dm_data_out = 32'h80FF_1234;
    @(negedge clk);
    check32("lb_data", W_wb_data, 32'hFFFF_FF80);
    check32("lb_we", {31'd0, W_reg_write}, 32'd1);

    // LHU / LH at 0x102
    set_m(LD, 3'd5, 32'h102, 5'd4, 1); tick();
    set_m(LD, 3'd1, 32'h102, 5'd4, 1); dm_data_out = 32'hBEEF_0000;
    @(negedge clk);
    check32("lhu_data", W_wb_data, 32'h0000_BEEF);
    tick();
    set_m(ALU, 3'd0, 32'h0, 5'd0, 0);
    @(negedge clk);
    check32("lh_data", W_wb_data, 32'hFFFF_BEEF);

    // LW then stall 3 cycles with dm changed
    set_m(LD, 3'd2, 32'h200, 5'd9, 1); tick();
    dm_data_out = 32'hDEAD_BEEF; set_m(ALU, 3'd0, 32'h77, 5'd1, 1);
    @(negedge clk);
    check32("lw_data", W_wb_data, 32'hDEAD_BEEF);
    stall = 1; tick();
    dm_data_out = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("lw_stall_hold", W_wb_data, 32'hDEAD_BEEF);
      tick();
    end
    stall = 0;

    // Flush vs. stall+flush
    set_m(ALU, 3'd0, 32'h42, 5'd5, 1); flush = 1; tick();
    flush = 0;
    @(negedge clk);
    check32("flush_we", {31'd0, W_reg_write}, 32'd0);
    check32("flush_data", W_wb_data, 32'h0);
    tick();
    @(negedge clk);
    check32("alu_data", W_wb_data, 32'h42);
    stall = 1; flush = 1; set_m(ALU, 3'd0, 32'h99, 5'd6, 1); tick();
    stall = 0; flush = 0;
    @(negedge clk);
    check32("stallflush_data", W_wb_data, 32'h42);
    check32("stallflush_rd", {27'd0, W_rd}, 32'd5);

    // rd=0 load, bad funct3 load
    set_m(LD, 3'd2, 32'h10, 5'd0, 1); tick();
    set_m(LD, 3'd3, 32'h10, 5'd8, 1); dm_data_out = 32'h1111_2222;
    @(negedge clk);
    check32("rd0_we", {31'd0, W_reg_write}, 32'd0);
    tick();
    set_m(ALU, 3'd0, 32'h0, 5'd0, 0);
    @(negedge clk);
    check32("badf3_data", W_wb_data, 32'h0);
    check32("badf3_we", {31'd0, W_reg_write}, 32'd0);

    // Reset during a stalled load, then a fresh load uses live data
    set_m(LD, 3'd2, 32'h20, 5'd2, 1); tick();
    dm_data_out = 32'hAAAA_5555; stall = 1; tick();
    dm_data_out = 32'h0; tick();
    rst = 1; tick();
    rst = 0; stall = 0;
    @(negedge clk);
    check32("rst_data", W_wb_data, 32'h0);
    check32("rst_isload", {31'd0, W_is_load}, 32'd0);
    set_m(LD, 3'd2, 32'h24, 5'd2, 1); tick();
    dm_data_out = 32'h1357_9BDF; stall = 1;
    @(negedge clk);
    check32("post_rst_live", W_wb_data, 32'h1357_9BDF);
    tick(); stall = 0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(99) < 2);
      stall = ($urandom_range(99) < 30);
      flush = ($urandom_range(99) < 10);
      set_m(($urandom_range(1) != 0) ? LD : ALU, 3'($urandom_range(7)),
            $urandom, 5'($urandom_range(31)), 1'($urandom_range(1)));
      dm_data_out = $urandom;
      tick();
    end

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
